// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller around an external two-port SRAM
// (port A = registered read, port B = write). Words are written at
// wr_ptr on each accepted push. A read is issued at rd_ptr whenever a
// stored word exists and the single output stage is free or is being
// popped. The SRAM read register acts as the output stage: out_data is
// sram_qa, which is held while sram_cena stays high.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear of all contents
//   in_valid/in_ready/in_data     producer handshake
//   out_valid/out_ready/out_data  consumer handshake (out_data = sram_qa)
//   sram_aa/sram_cena/sram_qa     SRAM read port (cena active low)
//   sram_ab/sram_cenb/sram_db     SRAM write port (cenb active low)
//   count           words written but not yet read-issued
module sram_fifo_ctrl #(
  parameter int unsigned WWORD = 32,
  parameter int unsigned WADDR = 5,
  parameter int unsigned DEPTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WWORD-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WWORD-1:0] out_data,
  output logic [WADDR-1:0] sram_aa,
  output logic             sram_cena,
  input  logic [WWORD-1:0] sram_qa,
  output logic [WADDR-1:0] sram_ab,
  output logic             sram_cenb,
  output logic [WWORD-1:0] sram_db,
  output logic [WADDR:0]   count
);

  localparam logic [WADDR-1:0] LAST_PTR  = WADDR'(DEPTH - 1);
  localparam logic [WADDR:0]   DEPTH_CNT = (WADDR + 1)'(DEPTH);
  localparam logic [WADDR-1:0] PTR_ONE   = {{(WADDR - 1){1'b0}}, 1'b1};
  localparam logic [WADDR:0]   CNT_ONE   = {{WADDR{1'b0}}, 1'b1};

  logic [WADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [WADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [WADDR:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             push, issue;

  always_comb begin
    in_ready = (count_q < DEPTH_CNT) && !flush && !rst;
    push     = in_valid && in_ready;
    // count only covers words already in the SRAM, so a word pushed this
    // cycle cannot be read until the next one (no same-address collision).
    issue    = (count_q != '0) && (!out_valid_q || out_ready) && !flush && !rst;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    if (issue) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;

    case ({push, issue})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new read refills the output stage; a pop without refill empties it.
    if (issue)          out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    sram_cenb = !push;
    sram_ab   = wr_ptr_q;
    sram_db   = in_data;
    sram_cena = !issue;
    sram_aa   = rd_ptr_q;
    out_data  = sram_qa;
    out_valid = out_valid_q;
    count     = count_q;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: a per-cycle vector table for the basic
// handshake/flush/reset behaviour, then hand-written sequences for
// streaming, fill, wrap, backpressure, flush and mid-stream reset, with
// a queue scoreboard and an SRAM behavioural model.
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 24;

  logic        clk;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data, sram_qa, sram_db;
  logic [4:0]  sram_aa, sram_ab;
  logic        sram_cena, sram_cenb;
  logic [5:0]  count;

  sram_fifo_ctrl #(.WWORD(32), .WADDR(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_aa(sram_aa), .sram_cena(sram_cena), .sram_qa(sram_qa),
    .sram_ab(sram_ab), .sram_cenb(sram_cenb), .sram_db(sram_db),
    .count(count)
  );

  // SRAM model: registered read, data held while cena is high.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (!sram_cenb) mem[sram_ab] <= sram_db;
    if (!sram_cena) sram_qa <= mem[sram_aa];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        r, f, iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir, e_ov, e_cena, e_cenb;
    logic [4:0]  e_ab, e_aa;
    logic [5:0]  e_cnt;
    logic [31:0] e_od;
  } vec_t;

  function automatic vec_t v(input logic r, f, iv, input logic [31:0] d, input logic ordy,
                             input logic ir, ov, cena, cenb, input logic [4:0] ab, aa,
                             input logic [5:0] cnt, input logic [31:0] od);
    vec_t x;
    x.r = r; x.f = f; x.iv = iv; x.d = d; x.ordy = ordy;
    x.e_ir = ir; x.e_ov = ov; x.e_cena = cena; x.e_cenb = cenb;
    x.e_ab = ab; x.e_aa = aa; x.e_cnt = cnt; x.e_od = od;
    return x;
  endfunction

  vec_t tbl [14];

  // Scoreboard state
  logic [31:0] sb [$];
  int          exp_wr = 0;
  int          exp_rd = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  task automatic step(input bit r, input bit f, input bit iv, input logic [31:0] d,
                      input bit ordy, output bit acc);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    acc = 0;
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
    end
    if (r || f) begin
      chk("ctl_in_ready", in_ready, 0);
      chk("ctl_cena", sram_cena, 1);
      chk("ctl_cenb", sram_cenb, 1);
    end else begin
      chk("push_en", sram_cenb, !(iv && in_ready));
      if (!sram_cenb) begin
        acc = 1;
        chk("wr_addr", sram_ab, exp_wr);
        chk("wr_data", sram_db, d);
        sb.push_back(d);
        exp_wr = (exp_wr == DEPTH - 1) ? 0 : exp_wr + 1;
      end
      if (!sram_cena) begin
        chk("rd_addr", sram_aa, exp_rd);
        exp_rd = (exp_rd == DEPTH - 1) ? 0 : exp_rd + 1;
      end
      if (out_valid && !ordy) chk("stall_cena", sram_cena, 1);
      if (out_valid && ordy) begin
        if (sb.size() == 0) chk("pop_underflow", 1, 0);
        else chk("pop_data", out_data, sb.pop_front());
      end
    end
    prev_stall = out_valid && !ordy && !r && !f;
    prev_data  = out_data;
    if (r || f) begin
      sb.delete();
      exp_wr = 0;
      exp_rd = 0;
    end
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      step(0, 0, 0, '0, 1, a);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 1, 0);
    step(0, 0, 0, '0, 1, a);
  endtask

  initial begin
    bit a;
    int idx;

    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (2) @(posedge clk);

    //            r f iv data          rdy ir ov cena cenb ab aa cnt out_data
    tbl[0]  = v(0,0,0, 32'h0,         1,  1, 0, 1,   1,   0, 0, 0, 32'h0);
    tbl[1]  = v(0,0,1, 32'h11111111,  1,  1, 0, 1,   0,   0, 0, 0, 32'h0);
    tbl[2]  = v(0,0,1, 32'h22222222,  1,  1, 0, 0,   0,   1, 0, 1, 32'h0);
    tbl[3]  = v(0,0,0, 32'h0,         0,  1, 1, 1,   1,   0, 0, 1, 32'h11111111);
    tbl[4]  = v(0,0,0, 32'h0,         0,  1, 1, 1,   1,   0, 0, 1, 32'h11111111);
    tbl[5]  = v(0,0,0, 32'h0,         1,  1, 1, 0,   1,   0, 1, 1, 32'h11111111);
    tbl[6]  = v(0,0,0, 32'h0,         1,  1, 1, 1,   1,   0, 0, 0, 32'h22222222);
    tbl[7]  = v(0,1,1, 32'h33333333,  1,  0, 0, 1,   1,   0, 0, 0, 32'h0);
    tbl[8]  = v(0,0,1, 32'h33333333,  1,  1, 0, 1,   0,   0, 0, 0, 32'h0);
    tbl[9]  = v(1,0,1, 32'h44444444,  1,  0, 0, 1,   1,   0, 0, 1, 32'h0);
    tbl[10] = v(0,0,1, 32'h44444444,  1,  1, 0, 1,   0,   0, 0, 0, 32'h0);
    tbl[11] = v(0,0,0, 32'h0,         1,  1, 0, 0,   1,   0, 0, 1, 32'h0);
    tbl[12] = v(0,0,0, 32'h0,         1,  1, 1, 1,   1,   0, 0, 0, 32'h44444444);
    tbl[13] = v(0,0,0, 32'h0,         1,  1, 0, 1,   1,   0, 0, 0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].r; flush = tbl[i].f; in_valid = tbl[i].iv;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_cena", i), sram_cena, tbl[i].e_cena);
      chk($sformatf("vec%0d_cenb", i), sram_cenb, tbl[i].e_cenb);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      if (!tbl[i].e_cenb) chk($sformatf("vec%0d_ab", i), sram_ab, tbl[i].e_ab);
      if (!tbl[i].e_cena) chk($sformatf("vec%0d_aa", i), sram_aa, tbl[i].e_aa);
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
    end

    // Streaming: each word appears two cycles after its push.
    step(1, 0, 0, '0, 1, a);
    step(0, 0, 0, '0, 1, a);
    for (int k = 0; k < 50; k++) begin
      step(0, 0, k < 48, 32'(k + 1), 1, a);
      chk("stream_out_valid", out_valid, (k >= 2 && k < 50));
      if (k >= 2) chk("stream_data", out_data, 32'(k - 1));
      chk("stream_count_le1", count <= 1, 1);
    end
    drain();

    // Fill/full: 25 accepted (24 stored + output stage), 26th held off.
    step(1, 0, 0, '0, 0, a);
    idx = 1;
    for (int c = 0; c < 40; c++) begin
      step(0, 0, idx <= 26, 32'(idx), 0, a);
      if (a) idx++;
    end
    chk("fill_accepted", idx - 1, 25);
    chk("fill_count", count, 24);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    drain();

    // Wrap: three fill/drain rounds starting at address 0.
    step(1, 0, 0, '0, 0, a);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int w = 0; w < DEPTH; w++) step(0, 0, 1, 32'h1000 * (rnd + 1) + 32'(w), 0, a);
      drain();
    end

    // Backpressure: random producer and consumer.
    for (int c = 0; c < 300; c++)
      step(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), a);
    drain();

    // Flush with 10 stored words and a valid output word.
    step(1, 0, 0, '0, 0, a);
    for (int w = 0; w < 11; w++) step(0, 0, 1, 32'hA000 + 32'(w), 0, a);
    step(0, 0, 0, '0, 0, a);
    chk("flush_pre_count", count, 10);
    chk("flush_pre_valid", out_valid, 1);
    step(0, 1, 1, 32'hDEAD, 0, a);
    step(0, 0, 0, '0, 0, a);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    step(0, 0, 1, 32'hBEEF, 1, a);
    chk("flush_ab0", sram_ab, 0);
    chk("flush_push", a, 1);
    drain();

    // Reset mid-stream with count=7.
    for (int w = 0; w < 8; w++) step(0, 0, 1, 32'hC000 + 32'(w), 0, a);
    step(0, 0, 0, '0, 0, a);
    chk("rst_pre_count", count, 7);
    step(1, 0, 1, 32'hFFFF, 1, a);
    step(0, 0, 0, '0, 1, a);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    for (int w = 0; w < 5; w++) begin
      step(0, 0, 1, 32'hD000 + 32'(w), 1, a);
      if (w == 0) chk("rst_first_ab", sram_ab, 0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 The block SHALL take parameter WWORD, default 32, meaning the data word width in bits.
REQ-002 The block SHALL take parameter WADDR, default 5, meaning the SRAM address width.
REQ-003 The block SHALL take parameter DEPTH, default 24, meaning the number of usable SRAM entries; DEPTH <= 2^WADDR.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  clk  input  1  the single clock; all logic is on its rising edge.
  rst  input  1  synchronous, active-high reset.
  flush  input  1  synchronous clear of all FIFO contents.
  in_valid  input  1  the producer offers in_data.
  in_ready  output  1  the block can accept a word this cycle.
  in_data  input  WWORD  the write word.
  out_valid  output  1  out_data holds the oldest unread word.
  out_ready  input  1  the consumer takes out_data this cycle.
  out_data  output  WWORD  the read word, driven directly from sram_qa.
  sram_aa  output  WADDR  SRAM read address.
  sram_cena  output  1  SRAM read enable, active low.
  sram_qa  input  WWORD  SRAM registered read data, 1-cycle latency, held while sram_cena is high.
  sram_ab  output  WADDR  SRAM write address.
  sram_cenb  output  1  SRAM write enable, active low.
  sram_db  output  WWORD  SRAM write data.
  count  output  WADDR+1  number of words written but not yet read-issued.

Function
REQ-005 A push SHALL occur in any cycle where in_valid && in_ready.
REQ-006 On a push, the block SHALL drive sram_cenb=0, sram_ab=wr_ptr and sram_db=in_data in that same cycle; otherwise sram_cenb=1.
REQ-007 in_ready SHALL equal (count < DEPTH) && !flush && !rst, with no same-cycle bypass from a pop.
REQ-008 A read issue SHALL occur in a cycle where count > 0 && (!out_valid || out_ready) && !flush.
REQ-009 On a read issue, the block SHALL drive sram_cena=0 and sram_aa=rd_ptr; otherwise sram_cena=1, so that sram_qa holds its value.
REQ-010 out_valid SHALL be set on the cycle after a read issue.
REQ-011 out_valid SHALL clear on the cycle after a pop (out_valid && out_ready) with no read issue.
REQ-012 out_valid SHALL stay 1 across back-to-back issue+pop cycles, giving throughput of 1 word per cycle.
REQ-013 While out_valid && !out_ready, out_data SHALL stay stable.
REQ-014 wr_ptr SHALL increment on each push, and rd_ptr on each read issue; each pointer SHALL wrap from DEPTH-1 to 0, never reaching values >= DEPTH.
REQ-015 count SHALL update next cycle as count + push - issue; a simultaneous push and issue SHALL leave count unchanged.
REQ-016 A word pushed in cycle t SHALL be read-issuable no earlier than cycle t+1, so the SRAM never sees a same-address read and write in one cycle.
REQ-017 Latency from an accepted push into an empty FIFO with out_ready=1 SHALL be: read issue at t+1, out_valid at t+2.
REQ-018 With count==DEPTH, in_ready SHALL be 0 and no push SHALL occur; a read issue in that cycle SHALL raise in_ready the next cycle.
REQ-019 With count==0, no read issue SHALL occur; an out_valid word already present SHALL remain valid until popped.
REQ-020 flush=1 SHALL, on the next edge, set wr_ptr=rd_ptr=0, count=0 and out_valid=0.
REQ-021 During a flush cycle, sram_cena and sram_cenb SHALL both be 1, and in_ready SHALL be 0.
REQ-022 out_data SHALL be ignored by consumers when out_valid=0; no value is required.

Reset
REQ-023 While rst=1 at a rising edge, wr_ptr, rd_ptr, count and out_valid SHALL become 0.
REQ-024 While rst=1, in_ready=0, sram_cena=1 and sram_cenb=1 SHALL hold combinationally.
REQ-025 Reset mid-operation SHALL discard all stored words; the first push after rst deasserts SHALL be written at address 0.
REQ-026 rst SHALL take priority over flush, push and read issue.

Verification
REQ-027 Streaming: out_ready=1; push 0x00000001..0x00000030 on consecutive cycles -> out_data returns 1..0x30 in order, each arriving 2 cycles after its push; count never exceeds 1.
REQ-028 Fill/full: out_ready=0; push 26 words -> in_ready drops after 24 accepted pushes plus 1 in the output stage (count=24); the 26th word is held off; sram_ab is never >= 24.
REQ-029 Wrap: run 3 full fill/drain rounds of 24 words -> sram_aa/sram_ab sequence 0..23,0..23,...; all data matches.
REQ-030 Backpressure: toggle out_ready randomly at 50% -> out_data is stable while stalled, and sram_cena=1 on every stalled cycle.
REQ-031 Flush: with 10 words stored and out_valid=1, pulse flush -> next cycle count=0, out_valid=0; the next push is written at sram_ab=0.
REQ-032 Reset mid-stream: assert rst for 1 cycle with count=7 -> all state is 0, no SRAM enables are asserted during rst, and subsequent data is uncorrupted.
